// File: rtl/pix_line_arbiter.sv
// Two-requester round-robin arbiter feeding whole pixel lines into the SCANLINE write port.
// Each grant carries exactly LINE_PIXELS accepted pixels unless the owner drops its request.
module pix_line_arbiter #(
  parameter int LINE_PIXELS = 640
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [1:0]  iREQ,
  input  logic [14:0] iRGB0,
  input  logic [14:0] iRGB1,
  input  logic        iWRITE0,
  input  logic        iWRITE1,
  output logic        oREADY0,
  output logic        oREADY1,
  output logic [1:0]  oGNT,
  output logic [14:0] oPIX_RGB,
  output logic        oPIX_WRITE,
  output logic        oPIX_START,
  input  logic        iPIX_FULL,
  output logic        oLINE_DONE,
  output logic        oABORT
);

  // state | meaning
  // IDLE  | no owner; a pending request is granted at the next edge
  // START | one-cycle start-of-line strobe, pixel counter cleared
  // BURST | owner streams pixels until the line is complete or it withdraws
  typedef enum logic [1:0] {IDLE, START, BURST} stateT;

  localparam int CNT_W = $clog2(LINE_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_PIXELS);

  stateT            state;
  stateT            stateNext;
  logic [1:0]       gntNext;
  logic             lastGnt;
  logic             lastGntNext;
  logic [CNT_W-1:0] pixCnt;
  logic [CNT_W-1:0] pixCntNext;
  logic             gntIdx;
  logic             accept;
  logic             lineDone;
  logic             abortNow;
  logic [14:0]      rgbSel;

  assign gntIdx  = oGNT[1];
  assign oREADY0 = oGNT[0] & ~iPIX_FULL & (state == BURST);
  assign oREADY1 = oGNT[1] & ~iPIX_FULL & (state == BURST);
  assign accept  = (oREADY0 & iWRITE0) | (oREADY1 & iWRITE1);
  assign rgbSel  = gntIdx ? iRGB1 : iRGB0;

  always_comb begin
    stateNext   = state;
    gntNext     = oGNT;
    lastGntNext = lastGnt;
    pixCntNext  = pixCnt;
    lineDone    = 1'b0;
    abortNow    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iREQ != 2'b00) begin
          stateNext = START;
          // on contention the requester not served last wins
          if (iREQ == 2'b11) gntNext = lastGnt ? 2'b01 : 2'b10;
          else               gntNext = iREQ;
        end
      end
      START: begin
        stateNext  = BURST;
        pixCntNext = '0;
      end
      BURST: begin
        if (accept) pixCntNext = pixCnt + 1'b1;
        if (accept && (pixCnt == LAST_CNT - 1'b1)) lineDone = 1'b1;
        else if (!iREQ[gntIdx])                    abortNow = 1'b1;
        if (lineDone || abortNow) begin
          stateNext   = IDLE;
          gntNext     = 2'b00;
          lastGntNext = gntIdx;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= IDLE;
      oGNT       <= 2'b00;
      lastGnt    <= 1'b1;
      pixCnt     <= '0;
      oPIX_RGB   <= '0;
      oPIX_WRITE <= 1'b0;
      oPIX_START <= 1'b0;
      oLINE_DONE <= 1'b0;
      oABORT     <= 1'b0;
    end else begin
      state      <= stateNext;
      oGNT       <= gntNext;
      lastGnt    <= lastGntNext;
      pixCnt     <= pixCntNext;
      oPIX_WRITE <= accept;
      if (accept) oPIX_RGB <= rgbSel;
      oPIX_START <= (stateNext == START);
      oLINE_DONE <= lineDone;
      oABORT     <= abortNow;
    end
  end

endmodule

// File: tb/tb_pix_line_arbiter.sv
// Bench for pix_line_arbiter: directed line scenarios then random traffic, all checked
// every cycle against a line-ownership model of the arbiter.
module tb_pix_line_arbiter;
  localparam int N = 4;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic [1:0]  iREQ;
  logic [14:0] iRGB0, iRGB1;
  logic        iWRITE0, iWRITE1;
  logic        oREADY0, oREADY1;
  logic [1:0]  oGNT;
  logic [14:0] oPIX_RGB;
  logic        oPIX_WRITE, oPIX_START;
  logic        iPIX_FULL;
  logic        oLINE_DONE, oABORT;

  pix_line_arbiter #(.LINE_PIXELS(N)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iREQ(iREQ),
    .iRGB0(iRGB0), .iRGB1(iRGB1), .iWRITE0(iWRITE0), .iWRITE1(iWRITE1),
    .oREADY0(oREADY0), .oREADY1(oREADY1), .oGNT(oGNT),
    .oPIX_RGB(oPIX_RGB), .oPIX_WRITE(oPIX_WRITE), .oPIX_START(oPIX_START),
    .iPIX_FULL(iPIX_FULL), .oLINE_DONE(oLINE_DONE), .oABORT(oABORT)
  );

  always #5 iCLK = ~iCLK;

  int vectors = 0;
  int miscompares = 0;

  // model: who owns the line, whether this is its start cycle, pixels taken so far
  int          owner;
  int          lastOwner;
  int          taken;
  bit          inStart;
  logic        expWrite, expDone, expAbort;
  logic [14:0] expRgb;

  logic [14:0] data0, data1;
  int          nWrite, nStart, nDone, nAbort;
  logic [14:0] wrData[$];
  logic [1:0]  gntLog[$];
  logic [1:0]  prevGnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner = -1; lastOwner = 1; taken = 0; inStart = 1'b0;
    expWrite = 1'b0; expDone = 1'b0; expAbort = 1'b0; expRgb = '0;
  endtask

  task automatic clearLog();
    nWrite = 0; nStart = 0; nDone = 0; nAbort = 0;
    wrData.delete(); gntLog.delete();
  endtask

  task automatic cyc(input logic rst, input logic [1:0] req, input logic w0, input logic w1,
                     input logic full);
    logic       rdy0, rdy1, acc0, acc1;
    logic [1:0] expGnt;
    iRESET = rst; iREQ = req; iWRITE0 = w0; iWRITE1 = w1; iPIX_FULL = full;
    iRGB0 = data0; iRGB1 = data1;
    @(negedge iCLK);
    expGnt = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    rdy0 = (owner == 0) && !inStart && !full;
    rdy1 = (owner == 1) && !inStart && !full;
    chk("gnt",    16'(oGNT),       16'(expGnt));
    chk("start",  16'(oPIX_START), 16'(inStart));
    chk("ready0", 16'(oREADY0),    16'(rdy0));
    chk("ready1", 16'(oREADY1),    16'(rdy1));
    chk("write",  16'(oPIX_WRITE), 16'(expWrite));
    chk("rgb",    16'(oPIX_RGB),   16'(expRgb));
    chk("done",   16'(oLINE_DONE), 16'(expDone));
    chk("abort",  16'(oABORT),     16'(expAbort));
    if (oPIX_WRITE === 1'b1) begin nWrite++; wrData.push_back(oPIX_RGB); end
    if (oPIX_START === 1'b1) nStart++;
    if (oLINE_DONE === 1'b1) nDone++;
    if (oABORT === 1'b1) nAbort++;
    if (oGNT !== 2'b00 && prevGnt === 2'b00) gntLog.push_back(oGNT);
    prevGnt = oGNT;
    acc0 = rdy0 && w0;
    acc1 = rdy1 && w1;
    if (rst) modelReset();
    else begin
      expWrite = acc0 || acc1;
      expDone = 1'b0;
      expAbort = 1'b0;
      if (acc0) expRgb = data0;
      if (acc1) expRgb = data1;
      if (owner < 0) begin
        if (req != 2'b00) begin
          owner = (req == 2'b11) ? 1 - lastOwner : (req[0] ? 0 : 1);
          inStart = 1'b1;
          taken = 0;
        end
      end else if (inStart) begin
        inStart = 1'b0;
      end else begin
        if (acc0 || acc1) taken++;
        if ((acc0 || acc1) && taken == N) begin
          expDone = 1'b1; lastOwner = owner; owner = -1;
        end else if (!req[owner[0]]) begin
          expAbort = 1'b1; lastOwner = owner; owner = -1;
        end
      end
      if (acc0) data0++;
      if (acc1) data1++;
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic chkData(input string tag, input logic [14:0] first);
    for (int i = 0; i < N; i++)
      chk(tag, 16'((i < wrData.size()) ? wrData[i] : 15'h7fff), 16'(first + 15'(i)));
  endtask

  initial begin
    iRESET = 1'b1; iREQ = 2'b00; iRGB0 = '0; iRGB1 = '0;
    iWRITE0 = 1'b0; iWRITE1 = 1'b0; iPIX_FULL = 1'b0;
    data0 = 15'd1; data1 = 15'h100;
    repeat (2) @(posedge iCLK);
    #1;
    modelReset();
    prevGnt = 2'b00;
    clearLog();

    // single line from requester 0, pixels 1..4
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d1_writes", 16'(nWrite), 16'd4);
    chk("d1_starts", 16'(nStart), 16'd1);
    chk("d1_done", 16'(nDone), 16'd1);
    chk("d1_grants", 16'(gntLog.size()), 16'd1);
    chkData("d1_data", 15'd1);

    // both requesting across three lines: 01, 10, 01
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    clearLog();
    for (int i = 0; i < 18; i++) cyc(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d2_grants", 16'(gntLog.size()), 16'd3);
    chk("d2_g0", 16'((gntLog.size() > 0) ? gntLog[0] : 2'b00), 16'(2'b01));
    chk("d2_g1", 16'((gntLog.size() > 1) ? gntLog[1] : 2'b00), 16'(2'b10));
    chk("d2_g2", 16'((gntLog.size() > 2) ? gntLog[2] : 2'b00), 16'(2'b01));
    chk("d2_done", 16'(nDone), 16'd3);
    chk("d2_writes", 16'(nWrite), 16'd12);

    // FIFO full for three cycles mid-line
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    clearLog();
    data0 = 15'd1;
    for (int i = 0; i < 9; i++) cyc(1'b0, 2'b01, 1'b1, 1'b0, (i >= 4 && i <= 6));
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d3_writes", 16'(nWrite), 16'd4);
    chk("d3_done", 16'(nDone), 16'd1);
    chkData("d3_data", 15'd1);

    // requester 0 withdraws after two pixels, requester 1 waiting
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    clearLog();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("d4_abort", 16'(nAbort), 16'd1);
    chk("d4_nodone", 16'(nDone), 16'd0);
    chk("d4_writes", 16'(nWrite), 16'd2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d4_grants", 16'(gntLog.size()), 16'd2);
    chk("d4_g1", 16'((gntLog.size() > 1) ? gntLog[1] : 2'b00), 16'(2'b10));
    chk("d4_abort_once", 16'(nAbort), 16'd1);

    // reset in the middle of a line
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    clearLog();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d5_starts", 16'(nStart), 16'd2);
    chk("d5_noabort", 16'(nAbort), 16'd0);
    chk("d5_writes", 16'(nWrite), 16'd6);
    chk("d5_regrant", 16'((gntLog.size() > 1) ? gntLog[1] : 2'b00), 16'(2'b01));

    // random traffic with occasional resets
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      data0 = 15'($urandom_range(0, 32767));
      data1 = 15'($urandom_range(0, 32767));
      cyc(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
